// File: rtl/tick_gen_ctrl.sv
// Clock-enable generator and run controller for a 4-bit loadable down-counter.
// Optional strobe counter on tick_cnt is built when TICK_CNT_EN is defined.
module tick_gen_ctrl #(
    parameter int DIV_W  = 16,
    parameter int TCNT_W = 16
) (
    input  logic              clk,
    input  logic              r,
    input  logic [DIV_W-1:0]  div,
    input  logic              start,
    input  logic              stop,
    input  logic              oneshot,
    input  logic              tc_in,
    output logic              ld,
    output logic              ce_out,
    output logic              run,
    output logic              done,
    output logic              wrap,
    output logic [TCNT_W-1:0] tick_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [DIV_W-1:0] CNT_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

    state_t           state_reg, state_next;
    logic [DIV_W-1:0] cnt_reg;
    logic [DIV_W-1:0] div_l_reg;
    logic             cnt_zero;
    logic             strobe;

    assign cnt_zero = (cnt_reg == '0);

    always_ff @(posedge clk) begin
        if (r) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
            div_l_reg <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                S_LOAD: begin
                    div_l_reg <= div;
                    cnt_reg   <= div;
                end
                // Prescaler wraps back to the latched divisor, giving div_l+1 cycle spacing
                S_RUN:   cnt_reg <= cnt_zero ? div_l_reg : (cnt_reg - CNT_ONE);
                default: cnt_reg <= cnt_reg;
            endcase
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: if (start && !stop) state_next = S_LOAD;
            S_LOAD: state_next = stop ? S_IDLE : S_RUN;
            S_RUN: begin
                if (stop)                   state_next = S_IDLE;
                else if (oneshot && tc_in)  state_next = S_DONE;
            end
            S_DONE: begin
                if (stop)       state_next = S_IDLE;
                else if (start) state_next = S_LOAD;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        ld     = (state_reg == S_LOAD);
        run    = (state_reg == S_RUN);
        done   = (state_reg == S_DONE);
        // Suppressing the strobe at terminal count in one-shot keeps the counter parked at zero
        strobe = (state_reg == S_RUN) && cnt_zero && !stop && !(oneshot && tc_in);
        ce_out = strobe;
        wrap   = strobe && tc_in;
    end

`ifdef TICK_CNT_EN
    logic [TCNT_W-1:0] tick_cnt_reg;
    localparam logic [TCNT_W-1:0] TICK_ONE = {{(TCNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (r || state_reg == S_LOAD) begin
            tick_cnt_reg <= '0;
        end else if (strobe && (tick_cnt_reg != '1)) begin
            tick_cnt_reg <= tick_cnt_reg + TICK_ONE;
        end
    end

    assign tick_cnt = tick_cnt_reg;
`else
    assign tick_cnt = '0;
`endif

endmodule
